// File: rtl/bitstream_decoder_pkg.sv
// bitstream_pkg: shared types and Q-format scaling for the bitstream decoder.
// BITSTREAM_DEC_BIPOLAR_EN selects bipolar (signed, -1..+1) decoding in scale().
package bitstream_pkg;
  localparam int FRAC_BITS = 10;
  typedef logic [15:0] fixed16_t;
  typedef enum logic {ACC, STALL} dec_state_e;
  function automatic fixed16_t scale(input logic [31:0] sum, input int frac, input int sh);
    logic [31:0] u;
    u = (sum << frac) >> sh;
`ifdef BITSTREAM_DEC_BIPOLAR_EN
    return fixed16_t'((u << 1) - (32'd1 << frac));
`else
    return fixed16_t'(u);
`endif
  endfunction
endpackage

// File: rtl/bitstream_decoder_if.sv
// bitstream_decoder_if: input word and output estimate handshakes of the decoder.
interface bitstream_decoder_if #(parameter int BS_WIDTH = 32, parameter int OUT_W = 16);
  logic                in_valid;
  logic                in_ready;
  logic [BS_WIDTH-1:0] in_bits;
  logic                y_valid;
  logic                y_ready;
  logic [OUT_W-1:0]    y_out;
  modport master (output in_valid, in_bits, y_ready, input in_ready, y_valid, y_out);
  modport slave (input in_valid, in_bits, y_ready, output in_ready, y_valid, y_out);
endinterface

// File: rtl/bitstream_decoder_popcount.sv
// bs_popcount: combinational adder-tree popcount, built by recursive halving.
module bs_popcount #(
  parameter int BS_WIDTH = 32
) (
  input  logic [BS_WIDTH-1:0]       i_bits,
  output logic [$clog2(BS_WIDTH):0] o_cnt
);
  if (BS_WIDTH == 1) begin : g_leaf
    assign o_cnt = i_bits;
  end else begin : g_node
    localparam int H = BS_WIDTH / 2;
    logic [$clog2(H):0] w_lo, w_hi;
    bs_popcount #(.BS_WIDTH(H)) u_lo (.i_bits(i_bits[H-1:0]), .o_cnt(w_lo));
    bs_popcount #(.BS_WIDTH(H)) u_hi (.i_bits(i_bits[BS_WIDTH-1:H]), .o_cnt(w_hi));
    assign o_cnt = {1'b0, w_lo} + {1'b0, w_hi};
  end
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts ones over WINDOW bitstream words and emits a Q6.10 estimate.
// Define BITSTREAM_DEC_BIPOLAR_EN for signed bipolar output (see bitstream_pkg::scale).
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int BS_WIDTH  = 32,
  parameter int WINDOW    = 8,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = bitstream_pkg::FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  bitstream_decoder_if.slave  bus,
  output logic [15:0]         o_win_cnt
);
  localparam int SH = $clog2(BS_WIDTH * WINDOW);
  localparam int SW = SH + 1;
  localparam int CW = $clog2(WINDOW);
  localparam int PW = $clog2(BS_WIDTH) + 1;
  dec_state_e       r_state;
  logic [SW-1:0]    r_sum, r_pend, w_new;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_pop;
  logic             r_y_valid;
  logic [OUT_W-1:0] r_y_out;
  logic [15:0]      r_win_cnt;
  logic             w_accept, w_last, w_free;
  bs_popcount #(.BS_WIDTH(BS_WIDTH)) u_pop (.i_bits(bus.in_bits), .o_cnt(w_pop));
  assign bus.in_ready = r_state == ACC;
  assign bus.y_valid  = r_y_valid;
  assign bus.y_out    = r_y_out;
  assign o_win_cnt    = r_win_cnt;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_last       = r_cnt == CW'(WINDOW - 1);
  assign w_free       = !r_y_valid | bus.y_ready;
  assign w_new        = r_sum + SW'(w_pop);
  // A take clears y_valid unless a new result lands in the same edge (later assignment wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACC;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_y_valid <= 1'b0;
      r_y_out   <= '0;
      r_win_cnt <= '0;
    end else begin
      if (r_y_valid && bus.y_ready) r_y_valid <= 1'b0;
      if (i_clear) begin
        r_state <= ACC;
        r_sum   <= '0;
        r_cnt   <= '0;
        r_pend  <= '0;
      end else if (r_state == ACC && w_accept) begin
        if (w_last && w_free) begin
          r_y_out   <= OUT_W'(scale(32'(w_new), FRAC_BITS, SH));
          r_y_valid <= 1'b1;
          r_sum     <= '0;
          r_cnt     <= '0;
          r_win_cnt <= r_win_cnt + 16'd1;
        end else if (w_last) begin
          r_pend  <= w_new;
          r_state <= STALL;
        end else begin
          r_sum <= w_new;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_state == STALL && bus.y_ready) begin
        r_y_out   <= OUT_W'(scale(32'(r_pend), FRAC_BITS, SH));
        r_y_valid <= 1'b1;
        r_sum     <= '0;
        r_cnt     <= '0;
        r_win_cnt <= r_win_cnt + 16'd1;
        r_state   <= ACC;
      end
    end
  end
endmodule
